// File: rtl/ascon_out_serializer_pkg.sv
// ascon_out_serializer_pkg: widths, state encoding and byte helpers for the output serializer.
package ascon_out_serializer_pkg;
    localparam int WORD_SIZE       = 64;
    localparam int IN_WIDTH        = 2 * WORD_SIZE;
    localparam int OUT_WIDTH       = 32;
    localparam int KEEP_WIDTH      = OUT_WIDTH / 8;
    localparam int BEATS_PER_BLOCK = IN_WIDTH / OUT_WIDTH;
    localparam int BYTES_PER_BEAT  = OUT_WIDTH / 8;
    localparam int MAX_BYTES       = IN_WIDTH / 8;
    localparam int CNT_WIDTH       = 5;

    typedef enum logic {S_IDLE, S_SEND} ser_state_t;

    function automatic logic [CNT_WIDTH-1:0] clamp_nbytes(input logic [CNT_WIDTH-1:0] n);
        return n > CNT_WIDTH'(MAX_BYTES) ? CNT_WIDTH'(MAX_BYTES) : n;
    endfunction

    // Big-endian byte mask: the first n bytes (from the MSB side) are kept.
    function automatic logic [IN_WIDTH-1:0] byte_mask(input logic [CNT_WIDTH-1:0] n);
        return ~({IN_WIDTH{1'b1}} >> {n, 3'b000});
    endfunction
endpackage

// File: rtl/ascon_out_serializer_if.sv
// ascon_out_serializer_if: block input stream and beat output stream of the serializer.
interface ascon_out_serializer_if;
    import ascon_out_serializer_pkg::*;
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   in_data;
    logic [CNT_WIDTH-1:0]  in_nbytes;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_data;
    logic [KEEP_WIDTH-1:0] out_keep;
    logic                  out_last;

    modport master (
        input  in_valid, in_data, in_nbytes, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );
    modport slave (
        output in_valid, in_data, in_nbytes, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/ascon_out_serializer_keep_mask_gen.sv
// keep_mask_gen: maps remaining byte count to the beat's byte enables (MSB byte first).
module keep_mask_gen
    import ascon_out_serializer_pkg::*;
(
    input  logic [CNT_WIDTH-1:0]  remaining,
    output logic [KEEP_WIDTH-1:0] keep
);
    assign keep = ~({KEEP_WIDTH{1'b1}} >> remaining);
endmodule

// File: rtl/ascon_out_serializer.sv
// ascon_out_serializer: drains one 128-bit rate block as 32-bit valid/ready beats.
module ascon_out_serializer
    import ascon_out_serializer_pkg::*;
(
    input logic                    clk,
    input logic                    reset,
    ascon_out_serializer_if.master bus
);
    ser_state_t            state, state_n;
    logic [IN_WIDTH-1:0]   shreg;
    logic [CNT_WIDTH-1:0]  remaining;
    logic                  last_blk;
    logic                  final_beat;
    logic                  capture;
    logic                  transfer;
    logic [KEEP_WIDTH-1:0] keep;

    keep_mask_gen u_keep (.remaining(remaining), .keep(keep));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // in_ready also opens on the final-beat transfer so blocks stream without a bubble.
    always_comb begin
        final_beat    = remaining <= CNT_WIDTH'(BYTES_PER_BEAT);
        bus.out_valid = state == S_SEND;
        transfer      = bus.out_valid && bus.out_ready;
        bus.in_ready  = state == S_IDLE || (transfer && final_beat);
        capture       = bus.in_valid && bus.in_ready;
        bus.out_data  = bus.out_valid ? shreg[IN_WIDTH-1 -: OUT_WIDTH] : '0;
        bus.out_keep  = bus.out_valid ? keep : '0;
        bus.out_last  = bus.out_valid && last_blk && final_beat;
        state_n       = capture ? S_SEND : (transfer && final_beat) ? S_IDLE : state;
    end

    // Bytes past nbytes are zeroed at capture so they never reach out_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            remaining <= '0;
            last_blk  <= 1'b0;
        end else if (capture) begin
            shreg     <= bus.in_data & byte_mask(clamp_nbytes(bus.in_nbytes));
            remaining <= clamp_nbytes(bus.in_nbytes);
            last_blk  <= bus.in_last;
        end else if (transfer) begin
            shreg     <= shreg << OUT_WIDTH;
            remaining <= final_beat ? '0 : remaining - CNT_WIDTH'(BYTES_PER_BEAT);
        end
    end
endmodule

// File: tb/tb_ascon_out_serializer.sv
// tb_ascon_out_serializer: directed and random block streams checked against a byte-level model.
module tb_ascon_out_serializer;
    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        fin;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;

    logic [127:0] blk_data[8];
    logic [4:0]   blk_n[8];
    logic         blk_last[8];
    beat_t        q[$];

    ascon_out_serializer_if bus();
    ascon_out_serializer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: beat b carries bytes 4b..4b+3 of the block; bytes at or beyond nbytes are absent.
    task automatic push_block(input logic [127:0] data, input logic [4:0] n, input logic last);
        int nn = (n > 5'd16) ? 16 : int'(n);
        int nb = (nn == 0) ? 1 : (nn + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            beat_t e;
            e.d = '0;
            e.k = '0;
            for (int j = 0; j < 4; j++) begin
                int idx = 4 * b + j;
                if (idx < nn) begin
                    e.d[31 - 8 * j -: 8] = data[127 - 8 * idx -: 8];
                    e.k[3 - j] = 1'b1;
                end
            end
            e.fin = (b == nb - 1);
            e.l = last && e.fin;
            q.push_back(e);
        end
    endtask

    task automatic run_stream(input int nblk, input bit stall);
        int bi = 0;
        int cyc = 0;
        bit exp_ready, fire, cap;
        while ((bi < nblk || q.size() != 0) && cyc < 2000) begin
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid  = bi < nblk;
            if (bi < nblk) begin
                bus.in_data   = blk_data[bi];
                bus.in_nbytes = blk_n[bi];
                bus.in_last   = blk_last[bi];
            end
            #1;
            exp_ready = (q.size() == 0) || (bus.out_ready && q[0].fin);
            chk("in_ready", 128'(bus.in_ready), 128'(exp_ready));
            chk("out_valid", 128'(bus.out_valid), 128'(q.size() != 0));
            if (q.size() != 0) begin
                chk("out_data", 128'(bus.out_data), 128'(q[0].d));
                chk("out_keep", 128'(bus.out_keep), 128'(q[0].k));
                chk("out_last", 128'(bus.out_last), 128'(q[0].l));
            end
            fire = (q.size() != 0) && bus.out_ready;
            cap  = bus.in_valid && exp_ready;
            @(posedge clk);
            #1;
            if (fire) void'(q.pop_front());
            if (cap) begin
                push_block(blk_data[bi], blk_n[bi], blk_last[bi]);
                bi++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("stream_done", 128'(cyc < 2000), 128'(1));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
        chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        chk({tag, "_out_data"}, 128'(bus.out_data), 128'(0));
        chk({tag, "_out_keep"}, 128'(bus.out_keep), 128'(0));
        chk({tag, "_out_last"}, 128'(bus.out_last), 128'(0));
    endtask

    initial begin
        logic [127:0] ref_data;
        ref_data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_nbytes = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        reset = 1'b0;

        blk_data[0] = ref_data; blk_n[0] = 5'd16; blk_last[0] = 1'b1;
        run_stream(1, 0);
        blk_n[0] = 5'd6;
        run_stream(1, 0);
        blk_n[0] = 5'd0;
        run_stream(1, 0);
        blk_n[0] = 5'd16;
        run_stream(1, 1);
        blk_data[1] = ~ref_data; blk_n[1] = 5'd11; blk_last[1] = 1'b1; blk_last[0] = 1'b0;
        run_stream(2, 0);
        blk_n[0] = 5'd20; blk_n[1] = 5'd31; blk_last[0] = 1'b1;
        run_stream(2, 1);

        bus.in_valid = 1'b1;
        bus.in_data = ref_data;
        bus.in_nbytes = 5'd16;
        bus.in_last = 1'b1;
        bus.out_ready = 1'b1;
        push_block(ref_data, 5'd16, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("rst_mid_beat0", 128'(bus.out_data), 128'(q[0].d));
        @(posedge clk);
        #1;
        chk("rst_mid_beat1", 128'(bus.out_data), 128'(q[1].d));
        @(posedge clk);
        #1;
        q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_values("rst_mid");
        reset = 1'b0;
        blk_data[0] = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0; blk_n[0] = 5'd16; blk_last[0] = 1'b1;
        run_stream(1, 0);

        for (int it = 0; it < 40; it++) begin
            int nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                blk_data[b] = {$urandom, $urandom, $urandom, $urandom};
                blk_n[b] = 5'($urandom_range(0, 20));
                blk_last[b] = 1'($urandom_range(0, 1));
            end
            run_stream(nb, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
